// File: rtl/cnn_result_argmax.sv
// Argmax over each N_CLASS-word burst of IEEE-754 singles from the CNN; the winner is held
// behind a valid/ready handshake, and truncated or overrunning bursts raise a one-cycle err.
module cnn_result_argmax #(
   parameter int N_CLASS = 3,
   parameter int IDX_W   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [31:0]      in_data,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [IDX_W-1:0] out_class,
   output logic [31:0]      out_max,
   output logic             err
);
   typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

   typedef struct packed {
      logic [31:0]      key;
      logic [IDX_W-1:0] idx;
      logic [31:0]      bits;
   } best_t;

   localparam int CW = $clog2(N_CLASS + 1);
   localparam logic [CW-1:0] LAST = CW'(N_CLASS - 1);

   // Monotonic unsigned key: -0 folds onto +0, NaN sinks below -inf.
   function automatic logic [31:0] sort_key(input logic [31:0] b);
      logic [31:0] n;
      n = (b == 32'h8000_0000) ? 32'h0 : b;
      if (n[30:23] == 8'hFF && n[22:0] != 23'h0) return 32'h0;
      else if (!n[31])                           return {1'b1, n[30:0]};
      else                                       return ~n;
   endfunction

   state_t        state;
   logic [CW-1:0] cnt;
   best_t         best, nxt, first;
   logic          take_first;

   always_comb begin
      first      = '{key: sort_key(in_data), idx: '0, bits: in_data};
      nxt        = best;
      // Strictly greater only, so ties keep the earlier index.
      if (first.key > best.key)
         nxt = '{key: first.key, idx: IDX_W'(cnt), bits: in_data};
      take_first = in_valid && (state == IDLE || (state == HOLD && out_ready));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         best      <= '0;
         out_valid <= 1'b0;
         out_class <= '0;
         out_max   <= '0;
         err       <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            COLLECT: begin
               if (in_valid) begin
                  best <= nxt;
                  cnt  <= cnt + 1'b1;
                  if (cnt == LAST) begin
                     state     <= HOLD;
                     cnt       <= '0;
                     out_valid <= 1'b1;
                     out_class <= nxt.idx;
                     out_max   <= nxt.bits;
                  end
               end else begin
                  err   <= 1'b1;
                  cnt   <= '0;
                  state <= IDLE;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end else if (in_valid) begin
                  err <= 1'b1;
               end
            end
            default: ;
         endcase
         // Word 0 of a burst, from IDLE or in the same cycle as the handshake.
         if (take_first) begin
            best <= first;
            if (N_CLASS == 1) begin
               state     <= HOLD;
               cnt       <= '0;
               out_valid <= 1'b1;
               out_class <= '0;
               out_max   <= in_data;
            end else begin
               state <= COLLECT;
               cnt   <= CW'(1);
            end
         end
      end
   end
endmodule
